// File: rtl/dmem_pkg.sv
// Shared types and constants for the handshaked MEM-stage data memory.
package dmem_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;
  // Latency counter only has to hold RD_LAT_MAX-2.
  localparam int unsigned CNT_W      = $clog2(RD_LAT_MAX - 1);

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_width_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic [XLEN-1:0] rdata;
    logic            err;
  } dmem_rsp_t;

endpackage

// File: rtl/data_mem_hs_if.sv
// Request/response bundle between the MEM stage and the data memory.
interface data_mem_hs_if;
  import dmem_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [2:0]      req_func3;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_func3,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_func3,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting: store merge lanes/enables, access legality, load extraction.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic            we,
  input  logic [2:0]      func3,
  input  logic [1:0]      lane,
  input  logic            oob,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rword,
  output logic [3:0]      be_c,
  output logic [XLEN-1:0] wlane_c,
  output logic [XLEN-1:0] load_c,
  output logic            err_c
);

  logic        misal;
  logic        bad_f3;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Legality: alignment, width code, and no unsigned-width stores.
  always_comb begin
    misal  = 1'b0;
    bad_f3 = 1'b0;
    case (func3)
      MEM_B, MEM_BU: misal = 1'b0;
      MEM_H, MEM_HU: misal = lane[0];
      MEM_W:         misal = (lane != 2'b00);
      default:       bad_f3 = 1'b1;
    endcase
    if (we && func3[2]) bad_f3 = 1'b1;
    err_c = oob | misal | bad_f3;
  end

  // Store data is replicated across lanes so the enable alone picks the target.
  always_comb begin
    be_c    = 4'b0000;
    wlane_c = wdata;
    case (func3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << lane;
        wlane_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_c    = lane[1] ? 4'b1100 : 4'b0011;
        wlane_c = {2{wdata[15:0]}};
      end
      default: be_c = 4'b1111;
    endcase
    if (!we || err_c) be_c = 4'b0000;
  end

  always_comb begin
    byte_sel = rword[7:0];
    case (lane)
      2'd1:    byte_sel = rword[15:8];
      2'd2:    byte_sel = rword[23:16];
      2'd3:    byte_sel = rword[31:24];
      default: byte_sel = rword[7:0];
    endcase
    half_sel = lane[1] ? rword[31:16] : rword[15:0];
    load_c   = '0;
    if (!we && !err_c) begin
      case (func3)
        MEM_B:   load_c = {{24{byte_sel[7]}}, byte_sel};
        MEM_BU:  load_c = {24'h0, byte_sel};
        MEM_H:   load_c = {{16{half_sel[15]}}, half_sel};
        MEM_HU:  load_c = {16'h0, half_sel};
        MEM_W:   load_c = rword;
        default: load_c = '0;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_hs.sv
// Byte-addressable data memory with valid/ready request and fixed-latency registered response.
module data_mem_hs
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned RD_LAT      = 1
) (
  input logic          clk,
  input logic          rst,
  data_mem_hs_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT = (RD_LAT > 1) ? CNT_W'(RD_LAT - 2) : '0;

  logic [XLEN-1:0]  mem_q [DEPTH_WORDS];
  dmem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dmem_rsp_t        pend_q, pend_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [XLEN-1:0]  rsp_rdata_q, rsp_rdata_d;

  logic             req_ready_c;
  logic             accept_c;
  logic             oob_c;
  logic [AW-1:0]    idx_c;
  logic [XLEN-1:0]  rd_word_c;
  logic [XLEN-1:0]  wlane_c;
  logic [XLEN-1:0]  load_c;
  logic [3:0]       be_c;
  logic             err_c;

  // Ready is gated by rst so a request coinciding with reset is never taken.
  assign req_ready_c = ~rst & (state_q != WAIT);
  assign accept_c    = bus.req_valid & req_ready_c;
  assign idx_c       = bus.req_addr[AW+1:2];
  assign oob_c       = (bus.req_addr[XLEN-1:AW+2] != '0);
  assign rd_word_c   = mem_q[idx_c];

  dmem_lane_fmt u_fmt (
    .we      (bus.req_we),
    .func3   (bus.req_func3),
    .lane    (bus.req_addr[1:0]),
    .oob     (oob_c),
    .wdata   (bus.req_wdata),
    .rword   (rd_word_c),
    .be_c    (be_c),
    .wlane_c (wlane_c),
    .load_c  (load_c),
    .err_c   (err_c)
  );

  // Array is written at the acceptance edge; contents are never reset.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem_q[idx_c][8*i +: 8] <= wlane_c[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (accept_c) begin
          if (RD_LAT == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Result is captured at accept and only published on entry to RESP, so the
  // response registers hold their old value between pulses.
  always_comb begin
    pend_d      = pend_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept_c) begin
      pend_d.rdata = load_c;
      pend_d.err   = err_c;
    end
    if (state_d == RESP) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = pend_d.rdata;
      rsp_err_d   = pend_d.err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_hs.sv
// Scoreboard bench for data_mem_hs: one instance at RD_LAT=1, one at RD_LAT=3.
module tb_data_mem_hs;
  import dmem_pkg::*;

  localparam int unsigned DEPTH = 256;
  localparam int          TOUT  = 50;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rec_t;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  int   cyc        = 0;
  int   compared   = 0;
  int   mismatched = 0;
  rec_t exp1[$];
  rec_t obs1[$];
  rec_t exp3[$];
  rec_t obs3[$];

  data_mem_hs_if bus1();
  data_mem_hs_if bus3();

  data_mem_hs #(.DEPTH_WORDS(DEPTH), .RD_LAT(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));
  data_mem_hs #(.DEPTH_WORDS(DEPTH), .RD_LAT(3)) dut3 (.clk(clk), .rst(rst3), .bus(bus3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Response monitors: record every pulse with the cycle it appeared in.
  always @(negedge clk) begin
    rec_t r;
    if (bus1.rsp_valid === 1'b1) begin
      r.rdata = bus1.rsp_rdata; r.err = bus1.rsp_err; r.cyc = cyc;
      obs1.push_back(r);
    end
    if (bus3.rsp_valid === 1'b1) begin
      r.rdata = bus3.rsp_rdata; r.err = bus3.rsp_err; r.cyc = cyc;
      obs3.push_back(r);
    end
  end

  // Present one request, hold it until accepted, and book the expected response.
  task automatic drive(input int sel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3,
                       input bit want_rsp, input logic [31:0] erd, input logic eerr);
    int   n;
    int   lat;
    logic rdy;
    rec_t r;
    @(negedge clk);
    if (sel == 1) begin
      bus1.req_valid = 1'b1; bus1.req_we = we; bus1.req_addr = addr;
      bus1.req_wdata = wdata; bus1.req_func3 = f3;
    end else begin
      bus3.req_valid = 1'b1; bus3.req_we = we; bus3.req_addr = addr;
      bus3.req_wdata = wdata; bus3.req_func3 = f3;
    end
    n   = 0;
    rdy = (sel == 1) ? bus1.req_ready : bus3.req_ready;
    while (rdy !== 1'b1 && n < TOUT) begin
      @(negedge clk);
      n++;
      rdy = (sel == 1) ? bus1.req_ready : bus3.req_ready;
    end
    compared++;
    if (n >= TOUT) begin
      mismatched++;
      $display("FAIL accept_timeout sel=%0d addr=%h: req_ready never 1 within %0d cycles", sel, addr, TOUT);
    end else if (want_rsp) begin
      lat     = (sel == 1) ? 1 : 3;
      r.rdata = erd; r.err = eerr; r.cyc = cyc + lat;
      if (sel == 1) exp1.push_back(r);
      else          exp3.push_back(r);
    end
    @(posedge clk);
    #1;
    if (sel == 1) bus1.req_valid = 1'b0;
    else          bus3.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int sel, input int n);
    int k = 0;
    int have;
    have = (sel == 1) ? obs1.size() : obs3.size();
    while (have < n && k < TOUT) begin
      @(negedge clk);
      #1;
      k++;
      have = (sel == 1) ? obs1.size() : obs3.size();
    end
  endtask

  task automatic test_reset();
    rst1 = 1'b1;
    rst3 = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if (bus1.req_ready !== 1'b0 || bus3.req_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_ready got %b/%b required 0/0", bus1.req_ready, bus3.req_ready);
    end
    compared++;
    if (bus1.rsp_valid !== 1'b0 || bus1.rsp_err !== 1'b0 || bus1.rsp_rdata !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_rsp1 got v=%b e=%b d=%h required 0 0 00000000", bus1.rsp_valid, bus1.rsp_err, bus1.rsp_rdata);
    end
    compared++;
    if (bus3.rsp_valid !== 1'b0 || bus3.rsp_err !== 1'b0 || bus3.rsp_rdata !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_rsp3 got v=%b e=%b d=%h required 0 0 00000000", bus3.rsp_valid, bus3.rsp_err, bus3.rsp_rdata);
    end
    rst1 = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);
    compared++;
    if (bus1.req_ready !== 1'b1 || bus3.req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL post_reset_ready got %b/%b required 1/1", bus1.req_ready, bus3.req_ready);
    end
  endtask

  task automatic test_back_to_back();
    rec_t e, o;
    drive(1, 1'b1, 32'h100, 32'hDEADBEEF, MEM_W, 1'b1, 32'h0,        1'b0);
    drive(1, 1'b0, 32'h100, 32'h0,        MEM_W, 1'b1, 32'hDEADBEEF, 1'b0);
    drive(1, 1'b0, 32'h103, 32'h0,        MEM_B, 1'b1, 32'hFFFFFFDE, 1'b0);
    wait_rsp(1, exp1.size());
    while (exp1.size() > 0) begin
      e = exp1.pop_front();
      compared++;
      if (obs1.size() == 0) begin
        mismatched++;
        $display("FAIL b2b_rsp got none required d=%h e=%b", e.rdata, e.err);
      end else begin
        o = obs1.pop_front();
        if (o.rdata !== e.rdata || o.err !== e.err || o.cyc != e.cyc) begin
          mismatched++;
          $display("FAIL b2b_rsp got d=%h e=%b cyc=%0d required d=%h e=%b cyc=%0d", o.rdata, o.err, o.cyc, e.rdata, e.err, e.cyc);
        end
      end
    end
    compared++;
    if (obs1.size() != 0) begin
      mismatched++;
      $display("FAIL b2b_extra got %0d extra pulses required 0", obs1.size());
      obs1.delete();
    end
  endtask

  task automatic test_byte_lanes();
    rec_t e, o;
    drive(1, 1'b1, 32'h40, 32'h11223344, MEM_W,  1'b1, 32'h0,        1'b0);
    drive(1, 1'b1, 32'h41, 32'h123456AA, MEM_B,  1'b1, 32'h0,        1'b0);
    drive(1, 1'b1, 32'h42, 32'hCAFEBEEF, MEM_H,  1'b1, 32'h0,        1'b0);
    drive(1, 1'b0, 32'h40, 32'h0,        MEM_W,  1'b1, 32'hBEEFAA44, 1'b0);
    drive(1, 1'b0, 32'h42, 32'h0,        MEM_HU, 1'b1, 32'h0000BEEF, 1'b0);
    drive(1, 1'b0, 32'h42, 32'h0,        MEM_H,  1'b1, 32'hFFFFBEEF, 1'b0);
    drive(1, 1'b0, 32'h41, 32'h0,        MEM_BU, 1'b1, 32'h000000AA, 1'b0);
    drive(1, 1'b0, 32'h40, 32'h0,        MEM_B,  1'b1, 32'h00000044, 1'b0);
    wait_rsp(1, exp1.size());
    while (exp1.size() > 0) begin
      e = exp1.pop_front();
      compared++;
      if (obs1.size() == 0) begin
        mismatched++;
        $display("FAIL lanes_rsp got none required d=%h e=%b", e.rdata, e.err);
      end else begin
        o = obs1.pop_front();
        if (o.rdata !== e.rdata || o.err !== e.err || o.cyc != e.cyc) begin
          mismatched++;
          $display("FAIL lanes_rsp got d=%h e=%b cyc=%0d required d=%h e=%b cyc=%0d", o.rdata, o.err, o.cyc, e.rdata, e.err, e.cyc);
        end
      end
    end
  endtask

  task automatic test_errors();
    rec_t e, o;
    drive(1, 1'b1, 32'h102, 32'hFFFFFFFF, MEM_W,  1'b1, 32'h0, 1'b1);
    drive(1, 1'b0, 32'h101, 32'h0,        MEM_H,  1'b1, 32'h0, 1'b1);
    drive(1, 1'b1, 32'h101, 32'h0000FFFF, MEM_H,  1'b1, 32'h0, 1'b1);
    drive(1, 1'b0, 32'h400, 32'h0,        MEM_W,  1'b1, 32'h0, 1'b1);
    drive(1, 1'b0, 32'h100, 32'h0,        3'b011, 1'b1, 32'h0, 1'b1);
    drive(1, 1'b1, 32'h100, 32'h00000077, MEM_BU, 1'b1, 32'h0, 1'b1);
    drive(1, 1'b1, 32'h3FC, 32'hA5A50001, MEM_W,  1'b1, 32'h0, 1'b0);
    drive(1, 1'b0, 32'h3FC, 32'h0,        MEM_W,  1'b1, 32'hA5A50001, 1'b0);
    drive(1, 1'b0, 32'h100, 32'h0,        MEM_W,  1'b1, 32'hDEADBEEF, 1'b0);
    drive(1, 1'b0, 32'h102, 32'h0,        MEM_BU, 1'b1, 32'h000000AD, 1'b0);
    wait_rsp(1, exp1.size());
    while (exp1.size() > 0) begin
      e = exp1.pop_front();
      compared++;
      if (obs1.size() == 0) begin
        mismatched++;
        $display("FAIL err_rsp got none required d=%h e=%b", e.rdata, e.err);
      end else begin
        o = obs1.pop_front();
        if (o.rdata !== e.rdata || o.err !== e.err || o.cyc != e.cyc) begin
          mismatched++;
          $display("FAIL err_rsp got d=%h e=%b cyc=%0d required d=%h e=%b cyc=%0d", o.rdata, o.err, o.cyc, e.rdata, e.err, e.cyc);
        end
      end
    end
  endtask

  task automatic test_reset_on_accept();
    rec_t e, o;
    drive(1, 1'b1, 32'h80, 32'h12345678, MEM_W, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    rst1 = 1'b1;
    bus1.req_valid = 1'b1; bus1.req_we = 1'b1; bus1.req_addr = 32'h80;
    bus1.req_wdata = 32'h5; bus1.req_func3 = MEM_W;
    @(negedge clk);
    bus1.req_valid = 1'b0;
    rst1 = 1'b0;
    drive(1, 1'b0, 32'h80, 32'h0, MEM_W, 1'b1, 32'h12345678, 1'b0);
    wait_rsp(1, exp1.size());
    while (exp1.size() > 0) begin
      e = exp1.pop_front();
      compared++;
      if (obs1.size() == 0) begin
        mismatched++;
        $display("FAIL rst_accept_rsp got none required d=%h e=%b", e.rdata, e.err);
      end else begin
        o = obs1.pop_front();
        if (o.rdata !== e.rdata || o.err !== e.err || o.cyc != e.cyc) begin
          mismatched++;
          $display("FAIL rst_accept_rsp got d=%h e=%b cyc=%0d required d=%h e=%b cyc=%0d", o.rdata, o.err, o.cyc, e.rdata, e.err, e.cyc);
        end
      end
    end
  endtask

  task automatic test_latency3();
    rec_t e, o;
    int   first_cyc;
    drive(3, 1'b1, 32'h200, 32'h0BADF00D, MEM_W, 1'b1, 32'h0, 1'b0);
    fork
      drive(3, 1'b0, 32'h200, 32'h0, MEM_W, 1'b1, 32'h0BADF00D, 1'b0);
      begin
        @(negedge clk);
        compared++;
        if (bus3.req_ready !== 1'b0 || bus3.rsp_valid !== 1'b0 || bus3.rsp_rdata !== 32'h0) begin
          mismatched++;
          $display("FAIL lat_wait1 got rdy=%b v=%b d=%h required 0 0 00000000", bus3.req_ready, bus3.rsp_valid, bus3.rsp_rdata);
        end
        @(negedge clk);
        compared++;
        if (bus3.req_ready !== 1'b0 || bus3.rsp_valid !== 1'b0) begin
          mismatched++;
          $display("FAIL lat_wait2 got rdy=%b v=%b required 0 0", bus3.req_ready, bus3.rsp_valid);
        end
        @(negedge clk);
        compared++;
        if (bus3.req_ready !== 1'b1 || bus3.rsp_valid !== 1'b1) begin
          mismatched++;
          $display("FAIL lat_resp got rdy=%b v=%b required 1 1", bus3.req_ready, bus3.rsp_valid);
        end
      end
    join
    wait_rsp(3, exp3.size());
    first_cyc = -100;
    while (exp3.size() > 0) begin
      e = exp3.pop_front();
      compared++;
      if (obs3.size() == 0) begin
        mismatched++;
        $display("FAIL lat_rsp got none required d=%h e=%b", e.rdata, e.err);
      end else begin
        o = obs3.pop_front();
        if (o.rdata !== e.rdata || o.err !== e.err || o.cyc != e.cyc) begin
          mismatched++;
          $display("FAIL lat_rsp got d=%h e=%b cyc=%0d required d=%h e=%b cyc=%0d", o.rdata, o.err, o.cyc, e.rdata, e.err, e.cyc);
        end
        if (first_cyc < 0) first_cyc = o.cyc;
        else begin
          compared++;
          if (o.cyc != first_cyc + 3) begin
            mismatched++;
            $display("FAIL lat_spacing got cyc=%0d required %0d", o.cyc, first_cyc + 3);
          end
        end
      end
    end
    compared++;
    if (obs3.size() != 0) begin
      mismatched++;
      $display("FAIL lat_extra got %0d extra pulses required 0", obs3.size());
      obs3.delete();
    end
  endtask

  task automatic test_reset_midop();
    rec_t e, o;
    drive(3, 1'b1, 32'h20, 32'hCAFEF00D, MEM_W, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    compared++;
    if (obs3.size() != 0) begin
      mismatched++;
      $display("FAIL midop_dropped got %0d pulses required 0", obs3.size());
      obs3.delete();
    end
    drive(3, 1'b0, 32'h20, 32'h0, MEM_W, 1'b1, 32'hCAFEF00D, 1'b0);
    wait_rsp(3, exp3.size());
    while (exp3.size() > 0) begin
      e = exp3.pop_front();
      compared++;
      if (obs3.size() == 0) begin
        mismatched++;
        $display("FAIL midop_rsp got none required d=%h e=%b", e.rdata, e.err);
      end else begin
        o = obs3.pop_front();
        if (o.rdata !== e.rdata || o.err !== e.err || o.cyc != e.cyc) begin
          mismatched++;
          $display("FAIL midop_rsp got d=%h e=%b cyc=%0d required d=%h e=%b cyc=%0d", o.rdata, o.err, o.cyc, e.rdata, e.err, e.cyc);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst1 = 1'b1;
    rst3 = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0; bus1.req_func3 = '0;
    bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_addr = '0; bus3.req_wdata = '0; bus3.req_func3 = '0;
    test_reset();
    test_back_to_back();
    test_byte_lanes();
    test_errors();
    test_reset_on_accept();
    test_latency3();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
